pipeline_fetch: RTL and testbench

- Instruction-fetch (IF) stage and IF/ID pipeline register for the 5-stage RISC-V pipeline.
- Generates the PC, handshakes with instruction memory, and presents opcode/funct3/funct7 to the ID-stage control decoder.
- Absorbs stalls, branch redirects and halt from downstream.
- Bubbles always present opcode 7'h00, which the decoder treats as NOP. Any other undefined opcode would decode as HALT.

---
 rtl/pipeline_pkg.sv | 24 ++
 rtl/fetch_hold_buf.sv | 61 ++++++
 rtl/pipeline_fetch.sv | 206 ++++++++++++++++++++
 tb/tb_pipeline_fetch.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared definitions for the 5-stage RISC-V pipeline.
//   - Opcode constants seen by the ID-stage control decoder
//   - Instruction size in bytes used for PC stepping
//   - Fetch-stage state encoding
package pipeline_pkg;

  localparam logic [6:0] R_FORMAT   = 7'h33;
  localparam logic [6:0] I_FORMAT   = 7'h13;
  localparam logic [6:0] LOAD       = 7'h03;
  localparam logic [6:0] STORE      = 7'h23;
  localparam logic [6:0] BEQ        = 7'h63;
  // Bubbles present this opcode; the decoder treats it as NOP.
  localparam logic [6:0] NOP_OPCODE = 7'h00;

  localparam int unsigned INSTR_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    HOLD   = 2'd2,
    HALTED = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_hold_buf.sv
// Single-entry skid buffer for the fetch stage. Captures one returned
// instruction word (with its PC) while ID is stalled.
// Ports:
//   clk, reset         clock, asynchronous active-high reset
//   load               capture load_instr/load_pc
//   drain              entry consumed by IF/ID, clear valid
//   flush              discard the entry (wins over load and drain)
//   load_instr/load_pc word and address to capture
//   buf_valid/buf_instr/buf_pc  buffered entry
module fetch_hold_buf #(
  parameter int unsigned PC_WIDTH    = 64,
  parameter int unsigned INSTR_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load,
  input  logic                   drain,
  input  logic                   flush,
  input  logic [INSTR_WIDTH-1:0] load_instr,
  input  logic [PC_WIDTH-1:0]    load_pc,
  output logic                   buf_valid,
  output logic [INSTR_WIDTH-1:0] buf_instr,
  output logic [PC_WIDTH-1:0]    buf_pc
);

  logic                   valid_q, valid_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic [PC_WIDTH-1:0]    pc_q, pc_d;

  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      instr_d = load_instr;
      pc_d    = load_pc;
    end else if (drain) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
    end
  end

  assign buf_valid = valid_q;
  assign buf_instr = instr_q;
  assign buf_pc    = pc_q;

endmodule

// File: rtl/pipeline_fetch.sv
// Instruction-fetch stage plus IF/ID pipeline register.
// Generates the PC, runs a single-outstanding request handshake with
// instruction memory and presents opcode/funct3/funct7 to the decoder.
// Handles hazard stalls (via a one-entry hold buffer), branch redirects
// and a sticky halt.
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   imem_req/imem_addr              fetch request, held until imem_valid
//   imem_rdata/imem_valid           returned word and completion strobe
//   stall_in                        hold IF/ID and PC
//   branch_taken/branch_target      redirect and flush IF/ID
//   halt_in                         stop fetching until reset
//   if_id_valid/if_id_pc            IF/ID contents
//   opcode/funct3/funct7            decoder fields, zero for bubbles
//   halted                          sticky fetch-stopped flag
module pipeline_fetch
  import pipeline_pkg::*;
#(
  parameter int unsigned          PC_WIDTH    = 64,
  parameter int unsigned          INSTR_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0]  RESET_PC    = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   imem_req,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  input  logic                   imem_valid,
  input  logic                   stall_in,
  input  logic                   branch_taken,
  input  logic [PC_WIDTH-1:0]    branch_target,
  input  logic                   halt_in,
  output logic                   if_id_valid,
  output logic [PC_WIDTH-1:0]    if_id_pc,
  output logic [6:0]             opcode,
  output logic [2:0]             funct3,
  output logic [6:0]             funct7,
  output logic                   halted
);

  localparam logic [PC_WIDTH-1:0] PC_STEP = PC_WIDTH'(INSTR_BYTES);

  fetch_state_t           state_q, state_d;
  logic [PC_WIDTH-1:0]    pc_q, pc_d;
  logic [PC_WIDTH-1:0]    req_addr_q, req_addr_d;
  logic                   squash_q, squash_d;
  logic                   halted_q, halted_d;
  logic                   if_id_valid_q, if_id_valid_d;
  logic [PC_WIDTH-1:0]    if_id_pc_q, if_id_pc_d;
  logic [INSTR_WIDTH-1:0] if_id_instr_q, if_id_instr_d;

  logic                   buf_load, buf_drain, buf_flush;
  logic                   buf_valid;
  logic [INSTR_WIDTH-1:0] buf_instr;
  logic [PC_WIDTH-1:0]    buf_pc;
  logic [PC_WIDTH-1:0]    target_aligned;

  assign target_aligned = {branch_target[PC_WIDTH-1:2], 2'b00};

  fetch_hold_buf #(
    .PC_WIDTH    (PC_WIDTH),
    .INSTR_WIDTH (INSTR_WIDTH)
  ) u_hold_buf (
    .clk        (clk),
    .reset      (reset),
    .load       (buf_load),
    .drain      (buf_drain),
    .flush      (buf_flush),
    .load_instr (imem_rdata),
    .load_pc    (req_addr_q),
    .buf_valid  (buf_valid),
    .buf_instr  (buf_instr),
    .buf_pc     (buf_pc)
  );

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    req_addr_d    = req_addr_q;
    squash_d      = squash_q;
    halted_d      = halted_q;
    if_id_valid_d = if_id_valid_q;
    if_id_pc_d    = if_id_pc_q;
    if_id_instr_d = if_id_instr_q;
    buf_load      = 1'b0;
    buf_drain     = 1'b0;
    buf_flush     = 1'b0;

    unique case (state_q)
      IDLE: begin
        state_d = FETCH;
        if (branch_taken) begin
          pc_d       = target_aligned;
          req_addr_d = target_aligned;
        end else if (halt_in) begin
          halted_d      = 1'b1;
          if_id_valid_d = 1'b0;
          state_d       = HALTED;
        end
      end

      FETCH: begin
        if (branch_taken) begin
          pc_d          = target_aligned;
          if_id_valid_d = 1'b0;
          // A request already in flight keeps its address; the returned
          // word is dropped and the target is requested afterwards.
          if (imem_valid) begin
            req_addr_d = target_aligned;
            squash_d   = 1'b0;
          end else begin
            squash_d = 1'b1;
          end
        end else if (halt_in) begin
          halted_d      = 1'b1;
          if_id_valid_d = 1'b0;
          squash_d      = 1'b0;
          state_d       = HALTED;
        end else if (imem_valid) begin
          if (squash_q) begin
            req_addr_d = pc_q;
            squash_d   = 1'b0;
            if (!stall_in) begin
              if_id_valid_d = 1'b0;
            end
          end else if (stall_in) begin
            buf_load = 1'b1;
            state_d  = HOLD;
          end else begin
            if_id_valid_d = 1'b1;
            if_id_pc_d    = req_addr_q;
            if_id_instr_d = imem_rdata;
            pc_d          = req_addr_q + PC_STEP;
            req_addr_d    = req_addr_q + PC_STEP;
          end
        end else if (!stall_in) begin
          // ID consumed its instruction and nothing new arrived.
          if_id_valid_d = 1'b0;
        end
      end

      HOLD: begin
        if (branch_taken) begin
          pc_d          = target_aligned;
          req_addr_d    = target_aligned;
          if_id_valid_d = 1'b0;
          buf_flush     = 1'b1;
          state_d       = FETCH;
        end else if (halt_in) begin
          halted_d      = 1'b1;
          if_id_valid_d = 1'b0;
          buf_flush     = 1'b1;
          state_d       = HALTED;
        end else if (!stall_in && buf_valid) begin
          if_id_valid_d = 1'b1;
          if_id_pc_d    = buf_pc;
          if_id_instr_d = buf_instr;
          pc_d          = buf_pc + PC_STEP;
          req_addr_d    = buf_pc + PC_STEP;
          buf_drain     = 1'b1;
          state_d       = FETCH;
        end
      end

      HALTED: begin
        if_id_valid_d = 1'b0;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      req_addr_q    <= RESET_PC;
      squash_q      <= 1'b0;
      halted_q      <= 1'b0;
      if_id_valid_q <= 1'b0;
      if_id_pc_q    <= '0;
      if_id_instr_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      req_addr_q    <= req_addr_d;
      squash_q      <= squash_d;
      halted_q      <= halted_d;
      if_id_valid_q <= if_id_valid_d;
      if_id_pc_q    <= if_id_pc_d;
      if_id_instr_q <= if_id_instr_d;
    end
  end

  assign imem_req    = (state_q == FETCH);
  assign imem_addr   = {req_addr_q[PC_WIDTH-1:2], 2'b00};
  assign if_id_valid = if_id_valid_q;
  assign if_id_pc    = if_id_pc_q;
  assign opcode      = if_id_valid_q ? if_id_instr_q[6:0]   : NOP_OPCODE;
  assign funct3      = if_id_valid_q ? if_id_instr_q[14:12] : 3'd0;
  assign funct7      = if_id_valid_q ? if_id_instr_q[31:25] : 7'd0;
  assign halted      = halted_q;

endmodule

// File: tb/tb_pipeline_fetch.sv
module tb_pipeline_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_valid;
  logic        stall_in;
  logic        branch_taken;
  logic [63:0] branch_target;
  logic        halt_in;
  logic        if_id_valid;
  logic [63:0] if_id_pc;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        halted;

  int unsigned total = 0;
  int unsigned bad   = 0;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] w;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  pipeline_fetch #(
    .PC_WIDTH    (64),
    .INSTR_WIDTH (32),
    .RESET_PC    (64'h0)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .imem_valid    (imem_valid),
    .stall_in      (stall_in),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .halt_in       (halt_in),
    .if_id_valid   (if_id_valid),
    .if_id_pc      (if_id_pc),
    .opcode        (opcode),
    .funct3        (funct3),
    .funct7        (funct7),
    .halted        (halted)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    case (a)
      64'h0:   return 32'h0000_0033;
      64'h4:   return 32'h0010_0093;
      64'h8:   return 32'h0020_8133;
      64'hC:   return 32'h4020_8133;
      default: return {a[24:0], 7'h13} ^ 32'h0000_5000;
    endcase
  endfunction

  task automatic check_bubble(input string tag);
    check_eq({tag, "_valid"},  {63'd0, if_id_valid}, 64'd0);
    check_eq({tag, "_opcode"}, {57'd0, opcode},      64'd0);
    check_eq({tag, "_funct3"}, {61'd0, funct3},      64'd0);
    check_eq({tag, "_funct7"}, {57'd0, funct7},      64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_req"},    {63'd0, imem_req}, 64'd0);
    check_eq({tag, "_addr"},   imem_addr,         64'd0);
    check_eq({tag, "_ifidpc"}, if_id_pc,          64'd0);
    check_eq({tag, "_halted"}, {63'd0, halted},   64'd0);
    check_bubble(tag);
  endtask

  // One clock of stimulus. When acc is set the word at address a is
  // expected in IF/ID right after this edge.
  task automatic step(input logic v, input logic [63:0] a, input logic st,
                      input logic br, input logic [63:0] tgt, input logic hl,
                      input logic acc);
    exp_t e;
    logic [31:0] w;
    imem_valid    = v;
    imem_rdata    = v ? mem_word(a) : 32'hDEAD_BEEF;
    stall_in      = st;
    branch_taken  = br;
    branch_target = tgt;
    halt_in       = hl;
    if (acc) begin
      e.pc = a;
      e.w  = mem_word(a);
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    imem_valid    = 1'b0;
    imem_rdata    = 32'hDEAD_BEEF;
    stall_in      = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 64'd0;
    halt_in       = 1'b0;
    if (acc) begin
      if (sb.size() == 0) begin
        check_eq("sb_underflow", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        w = e.w;
        check_eq("sb_valid",  {63'd0, if_id_valid}, 64'd1);
        check_eq("sb_pc",     if_id_pc,             e.pc);
        check_eq("sb_opcode", {57'd0, opcode},      {57'd0, w[6:0]});
        check_eq("sb_funct3", {61'd0, funct3},      {61'd0, w[14:12]});
        check_eq("sb_funct7", {57'd0, funct7},      {57'd0, w[31:25]});
      end
    end
  endtask

  initial begin
    reset         = 1'b1;
    imem_valid    = 1'b0;
    imem_rdata    = 32'hDEAD_BEEF;
    stall_in      = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 64'd0;
    halt_in       = 1'b0;

    // Reset state, with a stray imem_valid that must be ignored.
    repeat (2) @(posedge clk);
    #1;
    imem_valid = 1'b1;
    @(posedge clk);
    #1;
    imem_valid = 1'b0;
    check_reset_outputs("reset");
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_eq("start_req",  {63'd0, imem_req}, 64'd1);
    check_eq("start_addr", imem_addr,         64'h0);

    // Back-to-back fetch.
    step(1, 64'h0, 0, 0, 0, 0, 1);
    check_eq("t1_addr4", imem_addr, 64'h4);
    step(1, 64'h4, 0, 0, 0, 0, 1);
    check_eq("t1_addr8", imem_addr, 64'h8);
    step(1, 64'h8, 0, 0, 0, 0, 1);
    check_eq("t1_addrC", imem_addr, 64'hC);

    // Stall while the word at 0xC returns: IF/ID holds 0x8, request drops.
    step(1, 64'hC, 1, 0, 0, 0, 0);
    for (int unsigned i = 0; i < 2; i++) begin
      check_eq("t2_req_hold", {63'd0, imem_req},    64'd0);
      check_eq("t2_pc_hold",  if_id_pc,             64'h8);
      check_eq("t2_vld_hold", {63'd0, if_id_valid}, 64'd1);
      step(0, 64'h0, 1, 0, 0, 0, 0);
    end
    check_eq("t2_req_hold3", {63'd0, imem_req}, 64'd0);
    check_eq("t2_pc_hold3",  if_id_pc,          64'h8);
    step(0, 64'hC, 0, 0, 0, 0, 1);
    check_eq("t2_req_rel",  {63'd0, imem_req}, 64'd1);
    check_eq("t2_addr_rel", imem_addr,         64'h10);

    // Branch while the request to 0x10 is outstanding.
    step(0, 64'h0, 0, 1, 64'h40, 0, 0);
    check_bubble("t3_br");
    check_eq("t3_addr_keep", imem_addr, 64'h10);
    step(0, 64'h0, 0, 0, 0, 0, 0);
    check_eq("t3_addr_keep2", imem_addr, 64'h10);
    step(1, 64'h10, 0, 0, 0, 0, 0);
    check_bubble("t3_drop");
    check_eq("t3_addr_tgt", imem_addr, 64'h40);
    step(1, 64'h40, 0, 0, 0, 0, 1);

    // Branch and halt together: branch wins, target is word-aligned.
    step(0, 64'h0, 0, 1, 64'h101, 1, 0);
    check_eq("t4_halted", {63'd0, halted}, 64'd0);
    check_bubble("t4_br");
    step(1, 64'h44, 0, 0, 0, 0, 0);
    check_eq("t4_addr_tgt", imem_addr, 64'h100);
    step(1, 64'h100, 0, 0, 0, 0, 1);
    check_eq("t4_halted2", {63'd0, halted}, 64'd0);

    // Halt with a request outstanding.
    step(0, 64'h0, 0, 0, 0, 1, 0);
    check_eq("t5_halted", {63'd0, halted},   64'd1);
    check_eq("t5_req",    {63'd0, imem_req}, 64'd0);
    check_bubble("t5_halt");
    step(1, 64'h104, 0, 0, 0, 0, 0);
    check_eq("t5_halted2", {63'd0, halted},   64'd1);
    check_eq("t5_req2",    {63'd0, imem_req}, 64'd0);
    check_bubble("t5_late");
    reset = 1'b1;
    #1;
    check_reset_outputs("t5_reset");
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_eq("t5_restart_addr", imem_addr, 64'h0);
    step(1, 64'h0, 0, 0, 0, 0, 1);

    // Asynchronous reset between edges while in HOLD.
    step(1, 64'h4, 1, 0, 0, 0, 0);
    check_eq("t6_hold_req", {63'd0, imem_req}, 64'd0);
    #2;
    reset = 1'b1;
    #1;
    check_reset_outputs("t6_async");
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_eq("t6_restart_req", {63'd0, imem_req}, 64'd1);

    // PC wraps modulo 2^64.
    step(1, 64'h0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFE, 0, 0);
    check_bubble("wrap_br");
    check_eq("wrap_addr_tgt", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    step(1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 0, 0, 1);
    check_eq("wrap_addr0", imem_addr, 64'h0);

    check_eq("sb_leftover", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
